// File: rtl/tx_pkg.sv
// Shared encodings for the Bluetooth-side UART transmitter.
package tx_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP, GAP} tx_state_e;

    localparam int   UART_DATA_BITS = 8;
    localparam logic TXD_IDLE       = 1'b1;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; every bit lasts max(cpd,1) clocks.
module uart_byte_tx
    import tx_pkg::*;
#(
    parameter int CPD_W = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CPD_W-1:0]          cpd,
    input  logic                      load,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      busy,
    output logic                      done,
    output logic                      txd
);

    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [CPD_W-1:0]          cnt_q, cnt_d, reload;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic                      txd_q, txd_d;
    logic                      tick;

    assign reload = (cpd == '0) ? '0 : cpd - 1'b1;
    assign tick   = (cnt_q == '0);
    assign done   = (state_q == STOP) && tick;
    assign busy   = (state_q != IDLE);
    assign txd    = txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        case (state_q)
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = sh_q[0];
                    bit_d   = '0;
                    cnt_d   = reload;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = reload;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        txd_d   = TXD_IDLE;
                    end else begin
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (tick) state_d = IDLE;
                else      cnt_d   = cnt_q - 1'b1;
            end
            default: ;
        endcase
        // Accepting a load in the final stop clock lets bytes of one word run back to back.
        if (load && (state_q == IDLE || done)) begin
            state_d = START;
            sh_d    = data;
            txd_d   = 1'b0;
            cnt_d   = reload;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            txd_q   <= TXD_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/transmitter_centre.sv
// Pulls words from the TFIFO and sends them high byte first as 8N1 frames toward the BT module.
module transmitter_centre
    import tx_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int CPD_W  = 10,
    parameter int BYTES  = WORD_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bt_state,
    input  logic              are_we_sending,
    input  logic [CPD_W-1:0]  cpd,
    input  logic [CPD_W-1:0]  timer_cap,
    input  logic [WORD_W-1:0] TFIFO_out,
    input  logic              TFIFO_empty,
    output logic              TFIFO_rd_en,
    output logic              fpga_txd,
    output logic              tx_busy,
    output logic              word_done,
    output logic [15:0]       words_sent
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    tx_state_e                 state_q, state_d;
    logic [WORD_W-1:0]         word_q, word_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CPD_W-1:0]          gap_q, gap_d;
    logic                      rd_en_q, rd_en_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [15:0]               words_q, words_d;
    logic                      go, byte_load, byte_done, byte_busy;
    logic [UART_DATA_BITS-1:0] byte_data;

    assign go = bt_state & are_we_sending & ~TFIFO_empty;

    // DATA here covers the whole START/DATA/STOP walk done by uart_byte_tx.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        rd_en_d   = 1'b0;
        done_d    = 1'b0;
        words_d   = words_q;
        byte_load = 1'b0;
        byte_data = word_q[WORD_W-1 -: UART_DATA_BITS];
        case (state_q)
            IDLE: begin
                if (go) begin
                    rd_en_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                byte_load = ~byte_busy;
                byte_data = TFIFO_out[WORD_W-1 -: UART_DATA_BITS];
                word_d    = TFIFO_out << UART_DATA_BITS;
                idx_d     = IDX_W'(BYTES - 1);
                state_d   = DATA;
            end
            DATA: begin
                if (byte_done) begin
                    if (idx_q != '0) begin
                        byte_load = 1'b1;
                        word_d    = word_q << UART_DATA_BITS;
                        idx_d     = idx_q - 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        words_d = words_q + 16'd1;
                        if (timer_cap != '0) begin
                            gap_d   = timer_cap - 1'b1;
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            words_q <= words_d;
        end
    end

    uart_byte_tx #(.CPD_W(CPD_W)) u_byte_tx (
        .clock (clock),
        .reset (reset),
        .cpd   (cpd),
        .load  (byte_load),
        .data  (byte_data),
        .busy  (byte_busy),
        .done  (byte_done),
        .txd   (fpga_txd)
    );

    assign TFIFO_rd_en = rd_en_q;
    assign tx_busy     = busy_q;
    assign word_done   = done_q;
    assign words_sent  = words_q;

endmodule

// File: tb/tb_transmitter_centre.sv
// Directed bench for transmitter_centre with a small TFIFO model and 8N1 frame checker.
module tb_transmitter_centre;

    logic        clock = 1'b0;
    logic        reset;
    logic        bt_state, are_we_sending;
    logic [9:0]  cpd, timer_cap;
    logic [15:0] TFIFO_out = 16'h0;
    logic        TFIFO_empty;
    logic        TFIFO_rd_en, fpga_txd, tx_busy, word_done;
    logic [15:0] words_sent;

    transmitter_centre dut (
        .clock          (clock),
        .reset          (reset),
        .bt_state       (bt_state),
        .are_we_sending (are_we_sending),
        .cpd            (cpd),
        .timer_cap      (timer_cap),
        .TFIFO_out      (TFIFO_out),
        .TFIFO_empty    (TFIFO_empty),
        .TFIFO_rd_en    (TFIFO_rd_en),
        .fpga_txd       (fpga_txd),
        .tx_busy        (tx_busy),
        .word_done      (word_done),
        .words_sent     (words_sent)
    );

    always #5 clock = ~clock;

    // TFIFO model: one writer per pointer, data valid the clock after rd_en.
    logic [15:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int bad_rd = 0;
    assign TFIFO_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (TFIFO_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_ptr < wr_ptr) begin
                TFIFO_out <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end else begin
                bad_rd <= bad_rd + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int ws_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    // Line level for bit slot b (0..19) of a word: start, 8 data LSB first, stop; high byte first.
    function automatic logic exp_bit(input logic [15:0] w, input int b);
        logic [7:0] by;
        int p;
        by = (b < 10) ? w[15:8] : w[7:0];
        p  = b % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    // Waits for the read strobe, checks the 2-clock latency and every clock of the frame.
    task automatic run_word(input logic [15:0] w, input int c, input int tc,
                            input bit do_push, input int drop_at);
        int n, lat, bad, ce, rd0;
        cpd       = 10'(c);
        timer_cap = 10'(tc);
        ce  = (c == 0) ? 1 : c;
        rd0 = rd_cnt;
        if (do_push) push(w);
        n = 0;
        while (!TFIFO_rd_en && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("rd_en seen", int'(TFIFO_rd_en), 1);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (fpga_txd && lat < 10);
        check("rd_en to start latency", lat, 2);
        bad = 0;
        for (int k = 0; k < 20 * ce; k++) begin
            if (k > 0) @(negedge clock);
            if (fpga_txd !== exp_bit(w, k / ce) || word_done !== 1'b0 || tx_busy !== 1'b1) bad++;
            if (k == drop_at) bt_state = 1'b0;
        end
        check("frame bits", bad, 0);
        @(negedge clock);
        ws_exp++;
        check("word_done pulse", int'(word_done), 1);
        check("words_sent", int'(words_sent), ws_exp);
        check("txd idle after frame", int'(fpga_txd), 1);
        check("single rd_en", rd_cnt - rd0, 1);
    endtask

    typedef struct {
        logic [15:0] word;
        int          cpd;
        int          tcap;
        bit          push;
        int          exp_words;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int viol, n, rd0;

        vecs[0] = '{16'hA55A, 11, 0, 1'b0, 1};
        vecs[1] = '{16'h1234,  0, 0, 1'b1, 2};
        vecs[2] = '{16'h00FF,  1, 0, 1'b1, 3};
        vecs[3] = '{16'h8001,  3, 2, 1'b1, 4};

        // Reset held with a non-empty FIFO and the link up.
        reset = 1'b0; bt_state = 1'b1; are_we_sending = 1'b1;
        cpd = 10'd11; timer_cap = 10'd0;
        push(16'hA55A);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (fpga_txd !== 1'b1 || TFIFO_rd_en !== 1'b0 || words_sent !== 16'd0
                || tx_busy !== 1'b0 || word_done !== 1'b0) viol++;
        end
        check("reset outputs", viol, 0);
        check("reset no reads", rd_cnt, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_word(vecs[i].word, vecs[i].cpd, vecs[i].tcap, vecs[i].push, -1);
            check("table words_sent", int'(words_sent), vecs[i].exp_words);
            viol = 0;
            for (int g = 0; g < vecs[i].tcap; g++) begin
                if (tx_busy !== 1'b1 || fpga_txd !== 1'b1) viol++;
                @(negedge clock);
            end
            check("gap busy high", viol, 0);
            check("busy low after gap", int'(tx_busy), 0);
        end

        // Two queued words with a 385-clock gap: next rd_en only once the gap and IDLE clock pass.
        push(16'h0001);
        push(16'hFFFF);
        run_word(16'h0001, 4, 385, 1'b0, -1);
        n = 0; viol = 0;
        while (!TFIFO_rd_en && n < 1000) begin
            if (fpga_txd !== 1'b1) viol++;
            @(negedge clock);
            n++;
        end
        check("gap clocks before next rd_en", n, 386);
        check("line high through gap", viol, 0);
        run_word(16'hFFFF, 4, 385, 1'b0, -1);
        check("two-word words_sent", int'(words_sent), 6);
        repeat (390) @(negedge clock);

        // Link drops 30 clocks into the first byte; the word still finishes and nothing else is read.
        push(16'h1357);
        push(16'h2468);
        push(16'h9ABC);
        run_word(16'h1357, 4, 0, 1'b0, 30);
        rd0 = rd_cnt; viol = 0;
        for (int i = 0; i < 40; i++) begin
            if (TFIFO_rd_en !== 1'b0 || fpga_txd !== 1'b1 || tx_busy !== 1'b0) viol++;
            @(negedge clock);
        end
        check("held idle after bt drop", viol, 0);
        check("no rd after bt drop", rd_cnt - rd0, 0);
        check("fifo retains words", wr_ptr - rd_ptr, 2);
        bt_state = 1'b1;
        run_word(16'h2468, 4, 0, 1'b0, -1);
        run_word(16'h9ABC, 4, 0, 1'b0, -1);

        // Reset asserted while a zero data bit is on the line.
        push(16'h0000);
        cpd = 10'd4;
        n = 0;
        while (!TFIFO_rd_en && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("rd_en before mid-data reset", int'(TFIFO_rd_en), 1);
        repeat (12) @(negedge clock);
        check("txd low in data", int'(fpga_txd), 0);
        reset = 1'b0;
        #1;
        check("txd high on async reset", int'(fpga_txd), 1);
        check("words_sent cleared", int'(words_sent), 0);
        check("busy cleared", int'(tx_busy), 0);
        ws_exp = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        rd0 = rd_cnt; viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (TFIFO_rd_en !== 1'b0 || fpga_txd !== 1'b1 || tx_busy !== 1'b0) viol++;
        end
        check("idle after reset, fifo empty", viol, 0);
        check("no rd after reset", rd_cnt - rd0, 0);
        check("rd_en while empty", bad_rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
